// File: rtl/ff_mb_xfer_sched.sv
// Shares one multi-bit CDC flag/data synchronizer among N_REQ source requesters.
// Define FF_MB_SCHED_RR_EN for round-robin arbitration; the default build is fixed priority.
module ff_mb_xfer_sched #(
    parameter int DATA_W = 16,
    parameter int N_REQ  = 2,
    parameter int GAP    = 3,
    localparam int TAG_W = $clog2(N_REQ)
) (
    input  logic                      src_clk,
    input  logic                      src_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    output logic [N_REQ-1:0]          o_ack,
    output logic                      o_xfer_req,
    output logic [TAG_W+DATA_W-1:0]   o_xfer_data,
    output logic                      o_busy
);

    localparam int CW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t           state;
    logic [CW-1:0]    gap_cnt;
    logic [TAG_W-1:0] win;

`ifdef FF_MB_SCHED_RR_EN
    logic [TAG_W-1:0] last;
    logic             found;
    int               idx;

    // Search starts just past the last grant so every requester gets a turn.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!found && i_req[idx]) begin
                win   = TAG_W'(idx);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                win = TAG_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge src_clk) begin
        if (!src_rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            o_xfer_req  <= 1'b0;
            o_ack       <= '0;
            o_xfer_data <= '0;
            o_busy      <= 1'b0;
`ifdef FF_MB_SCHED_RR_EN
            last        <= TAG_W'(N_REQ - 1);
`endif
        end else begin
            o_xfer_req <= 1'b0;
            o_ack      <= '0;
            unique case (state)
                IDLE: begin
                    if (|i_req) begin
                        state       <= ISSUE;
                        o_xfer_req  <= 1'b1;
                        o_ack       <= N_REQ'(1) << win;
                        o_xfer_data <= {win, i_data[int'(win)*DATA_W +: DATA_W]};
                        o_busy      <= 1'b1;
`ifdef FF_MB_SCHED_RR_EN
                        last        <= win;
`endif
                    end
                end
                ISSUE: begin
                    state   <= HOLD;
                    gap_cnt <= CW'(GAP - 2);
                end
                HOLD: begin
                    // Requests seen here are ignored; the gap protects the synchronizer.
                    if (gap_cnt <= CW'(1)) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                        o_busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_mb_xfer_sched.sv
// Scoreboard bench for ff_mb_xfer_sched: a 2-requester GAP=3 instance
// and a 4-requester GAP=5 instance share one clock and reset.
module tb_ff_mb_xfer_sched;

    typedef struct {
        int          cyc;
        logic [3:0]  ack;
        logic [17:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_a;
    logic [31:0] data_a;
    logic [1:0]  ack_a;
    logic        xreq_a;
    logic [16:0] xdata_a;
    logic        busy_a;
    logic [3:0]  req_b;
    logic [63:0] data_b;
    logic [3:0]  ack_b;
    logic        xreq_b;
    logic [17:0] xdata_b;
    logic        busy_b;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    ff_mb_xfer_sched #(.DATA_W(16), .N_REQ(2), .GAP(3)) dut_a (
        .src_clk    (clk),
        .src_rst_n  (rst_n),
        .i_req      (req_a),
        .i_data     (data_a),
        .o_ack      (ack_a),
        .o_xfer_req (xreq_a),
        .o_xfer_data(xdata_a),
        .o_busy     (busy_a)
    );

    ff_mb_xfer_sched #(.DATA_W(16), .N_REQ(4), .GAP(5)) dut_b (
        .src_clk    (clk),
        .src_rst_n  (rst_n),
        .i_req      (req_b),
        .i_data     (data_b),
        .o_ack      (ack_b),
        .o_xfer_req (xreq_b),
        .o_xfer_data(xdata_b),
        .o_busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input int c, input int g, input logic [15:0] p);
        exp_t e;
        e.cyc  = c;
        e.ack  = 4'(1 << g);
        e.data = {2'(g), p};
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input int g, input logic [15:0] p);
        exp_t e;
        e.cyc  = c;
        e.ack  = 4'(1 << g);
        e.data = {2'(g), p};
        qb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (xreq_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_strobe", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a_strobe_cycle", cyc, e.cyc);
                check("a_ack", ack_a, e.ack);
                check("a_xfer_data", xdata_a, e.data);
            end
        end else if (ack_a != '0) begin
            check("a_ack_without_strobe", ack_a, 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (xreq_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_strobe", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b_strobe_cycle", cyc, e.cyc);
                check("b_ack", ack_b, e.ack);
                check("b_xfer_data", xdata_b, e.data);
            end
        end else if (ack_b != '0) begin
            check("b_ack_without_strobe", ack_b, 0);
        end
    end

    initial begin
        int c;
        rst_n  = 1'b0;
        req_a  = '0;
        req_b  = '0;
        data_a = '0;
        data_b = '0;
        tick(2);
        check("rst_xfer_req", xreq_a, 0);
        check("rst_ack", ack_a, 0);
        check("rst_xfer_data", xdata_a, 0);
        check("rst_busy", busy_a, 0);
        rst_n = 1'b1;
        tick(1);

        // single request, latency and busy width
        c = cyc;
        data_a[15:0] = 16'hA5A5;
        req_a = 2'b01;
        push_a(c + 1, 0, 16'hA5A5);
        tick(1);
        check("t1_busy_issue", busy_a, 1);
        req_a = 2'b00;
        tick(1);
        check("t1_busy_hold", busy_a, 1);
        tick(1);
        check("t1_busy_idle", busy_a, 0);
        tick(2);

        // continuous load from both requesters
        do_reset();
        c = cyc;
        data_a = {16'h2222, 16'h1111};
        req_a = 2'b11;
`ifdef FF_MB_SCHED_RR_EN
        push_a(c + 1, 0, 16'h1111);
        push_a(c + 4, 1, 16'h2222);
        push_a(c + 7, 0, 16'h1111);
        push_a(c + 10, 1, 16'h2222);
`else
        push_a(c + 1, 0, 16'h1111);
        push_a(c + 4, 0, 16'h1111);
        push_a(c + 7, 0, 16'h1111);
        push_a(c + 10, 0, 16'h1111);
`endif
        tick(10);
        req_a = 2'b00;
        tick(4);

        // same requester re-requests with new data right after ack
        c = cyc;
        data_a[15:0] = 16'h0001;
        req_a = 2'b01;
        push_a(c + 1, 0, 16'h0001);
        push_a(c + 4, 0, 16'h0002);
        tick(1);
        data_a[15:0] = 16'h0002;
        tick(3);
        req_a = 2'b00;
        tick(4);

        // reset during ISSUE aborts, held request re-granted after release
        c = cyc;
        data_a[31:16] = 16'hBEEF;
        req_a = 2'b10;
        push_a(c + 1, 1, 16'hBEEF);
        push_a(c + 3, 1, 16'hBEEF);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check("t5_rst_xfer_req", xreq_a, 0);
        check("t5_rst_ack", ack_a, 0);
        check("t5_rst_xfer_data", xdata_a, 0);
        check("t5_rst_busy", busy_a, 0);
        rst_n = 1'b1;
        tick(1);
        req_a = 2'b00;
        tick(4);

        // request pulsed only while in HOLD is ignored
        c = cyc;
        data_a[15:0] = 16'h0C0C;
        req_a = 2'b01;
        push_a(c + 1, 0, 16'h0C0C);
        tick(1);
        req_a = 2'b00;
        tick(1);
        req_a = 2'b10;
        tick(1);
        req_a = 2'b00;
        check("t6_no_strobe_0", xreq_a, 0);
        tick(1);
        check("t6_no_strobe_1", xreq_a, 0);
        check("t6_no_ack", ack_a, 0);
        tick(3);

        // 4 requesters, GAP=5: set last=1, then 1010
        c = cyc;
        data_b[31:16] = 16'h1234;
        req_b = 4'b0010;
        push_b(c + 1, 1, 16'h1234);
        tick(1);
        req_b = 4'b0000;
        tick(5);
        c = cyc;
        data_b[31:16] = 16'h5555;
        data_b[63:48] = 16'h3333;
        req_b = 4'b1010;
`ifdef FF_MB_SCHED_RR_EN
        push_b(c + 1, 3, 16'h3333);
        push_b(c + 6, 1, 16'h5555);
        tick(1);
        req_b = 4'b0010;
`else
        push_b(c + 1, 1, 16'h5555);
        push_b(c + 6, 3, 16'h3333);
        tick(1);
        req_b = 4'b1000;
`endif
        tick(5);
        req_b = 4'b0000;
        tick(6);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
